// File: rtl/pulse_sync_scheduler.sv
// Round-robin scheduler feeding one shared pulse-synchronizer channel from NUM_REQ requesters.
// Optional issue/timeout statistics counters are enabled by defining PULSE_SYNC_SCHED_STATS_EN.
module pulse_sync_scheduler #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned GAP_CYCLES = 3,
  parameter int unsigned TIMEOUT    = 64,
  localparam int unsigned ID_W      = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [NUM_REQ-1:0] req_pulse,
  output logic               sync_pulse,
  output logic [ID_W-1:0]    sync_id,
  input  logic               sync_ack,
  output logic               busy,
  output logic [NUM_REQ-1:0] pending,
  output logic [NUM_REQ-1:0] drop,
  output logic               timeout_err
`ifdef PULSE_SYNC_SCHED_STATS_EN
  ,
  output logic [15:0]        issue_cnt,
  output logic [15:0]        timeout_cnt
`endif
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT);
  localparam int unsigned GAP_W  = $clog2(GAP_CYCLES + 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ISSUE    = 2'd1;
  localparam logic [1:0] WAIT_ACK = 2'd2;
  localparam logic [1:0] GAP      = 2'd3;

  logic [1:0]         state, state_d;
  logic [ID_W-1:0]    rr_ptr, rr_ptr_d;
  logic [ID_W-1:0]    sync_id_d;
  logic [ID_W-1:0]    sel_idx;
  logic               sel_vld;
  logic [NUM_REQ-1:0] grant_clr;
  logic [NUM_REQ-1:0] pending_d, drop_d;
  logic [WAIT_W-1:0]  wait_cnt, wait_cnt_d;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_d;
  logic               sync_pulse_d, timeout_err_d;
  int unsigned        cand;

  // First pending requester at or after rr_ptr, wrapping.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    cand    = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = 32'(rr_ptr) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!sel_vld && pending[ID_W'(cand)]) begin
        sel_vld = 1'b1;
        sel_idx = ID_W'(cand);
      end
    end
  end

  always_comb begin
    state_d       = state;
    rr_ptr_d      = rr_ptr;
    sync_id_d     = sync_id;
    wait_cnt_d    = wait_cnt;
    gap_cnt_d     = gap_cnt;
    grant_clr     = '0;
    sync_pulse_d  = 1'b0;
    timeout_err_d = 1'b0;

    case (state)
      IDLE: begin
        if (sel_vld) begin
          state_d            = ISSUE;
          sync_id_d          = sel_idx;
          grant_clr[sel_idx] = 1'b1;
          rr_ptr_d           = (sel_idx == ID_W'(NUM_REQ - 1)) ? '0 : sel_idx + ID_W'(1);
          sync_pulse_d       = 1'b1;
        end
      end
      ISSUE: begin
        state_d    = WAIT_ACK;
        wait_cnt_d = '0;
      end
      WAIT_ACK: begin
        // Ack takes priority over expiry on the final cycle.
        if (sync_ack) begin
          state_d   = GAP;
          gap_cnt_d = '0;
        end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
          state_d       = GAP;
          gap_cnt_d     = '0;
          timeout_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt + WAIT_W'(1);
        end
      end
      GAP: begin
        if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) state_d = IDLE;
        else gap_cnt_d = gap_cnt + GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase

    // A new request on the clearing edge re-arms the flag without a drop.
    drop_d    = req_pulse & pending & ~grant_clr;
    pending_d = (pending & ~grant_clr) | req_pulse;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      sync_id     <= '0;
      wait_cnt    <= '0;
      gap_cnt     <= '0;
      pending     <= '0;
      drop        <= '0;
      sync_pulse  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      rr_ptr      <= rr_ptr_d;
      sync_id     <= sync_id_d;
      wait_cnt    <= wait_cnt_d;
      gap_cnt     <= gap_cnt_d;
      pending     <= pending_d;
      drop        <= drop_d;
      sync_pulse  <= sync_pulse_d;
      timeout_err <= timeout_err_d;
    end
  end

  assign busy = (state != IDLE);

`ifdef PULSE_SYNC_SCHED_STATS_EN
  // Saturating event statistics.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      issue_cnt   <= '0;
      timeout_cnt <= '0;
    end else begin
      if (sync_pulse_d && (issue_cnt != 16'hFFFF)) issue_cnt <= issue_cnt + 16'd1;
      if (timeout_err_d && (timeout_cnt != 16'hFFFF)) timeout_cnt <= timeout_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pulse_sync_scheduler.sv
// Directed self-checking bench for pulse_sync_scheduler (default parameters, statistics disabled).
module tb_pulse_sync_scheduler;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [3:0] req_pulse;
  logic       sync_pulse;
  logic [1:0] sync_id;
  logic       sync_ack;
  logic       busy;
  logic [3:0] pending;
  logic [3:0] drop;
  logic       timeout_err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc_cnt  = 0;

  pulse_sync_scheduler dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .req_pulse  (req_pulse),
    .sync_pulse (sync_pulse),
    .sync_id    (sync_id),
    .sync_ack   (sync_ack),
    .busy       (busy),
    .pending    (pending),
    .drop       (drop),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_sync(input string tag, output int at);
    int n;
    n = 0;
    while (sync_pulse !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    at = cyc_cnt;
    check(tag, 32'(sync_pulse), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic ack_now();
    sync_ack = 1'b1;
    @(negedge clk);
    sync_ack = 1'b0;
  endtask

  // Pulse req, then expect n grants in the packed order, acking d cycles after each pulse.
  task automatic run_seq(input string tag, input logic [3:0] req, input logic [7:0] order,
                         input int n, input int d);
    int at, prev;
    logic [1:0] exp_id;
    prev = 0;
    req_pulse = req;
    @(negedge clk);
    req_pulse = '0;
    for (int k = 0; k < n; k++) begin
      wait_sync($sformatf("%s_seen%0d", tag, k), at);
      exp_id = order[2*k +: 2];
      check($sformatf("%s_id%0d", tag, k), 32'(sync_id), 32'(exp_id));
      if (k > 0) check($sformatf("%s_space%0d", tag, k), 32'(at - prev), 32'(5 + d));
      prev = at;
      repeat (d) @(negedge clk);
      ack_now();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int s, s2, cnt;
    n_rst = 1'b0;
    req_pulse = '0;
    sync_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sync_pulse", 32'(sync_pulse), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    check("rst_sync_id", 32'(sync_id), 32'd0);
    n_rst = 1'b1;
    @(negedge clk);

    // Single request: pulse two cycles after the request cycle, ack 5 cycles after pulse.
    req_pulse = 4'b0100;
    @(negedge clk);
    req_pulse = '0;
    check("single_pend_set", 32'(pending), 32'h4);
    check("single_no_pulse_yet", 32'(sync_pulse), 32'd0);
    @(negedge clk);
    check("single_pulse", 32'(sync_pulse), 32'd1);
    check("single_id", 32'(sync_id), 32'd2);
    check("single_busy", 32'(busy), 32'd1);
    check("single_pend_clr", 32'(pending), 32'd0);
    repeat (5) @(negedge clk);
    ack_now();
    check("single_gap_busy", 32'(busy), 32'd1);
    check("single_no_timeout", 32'(timeout_err), 32'd0);
    repeat (2) @(negedge clk);
    check("single_gap_end_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("single_idle", 32'(busy), 32'd0);
    check("single_pend_final", 32'(pending), 32'd0);

    // Round robin from rr_ptr=0, then from rr_ptr=2.
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    run_seq("rr0", 4'b1111, 8'hE4, 4, 2);
    wait_idle("rr0_idle");
    run_seq("rr_one", 4'b0010, 8'h01, 1, 2);
    wait_idle("rr_one_idle");
    run_seq("rr2", 4'b1111, 8'h4E, 4, 2);
    wait_idle("rr2_idle");

    // Drop: requester 1 pulses twice while event 0 waits for ack.
    req_pulse = 4'b0001;
    @(negedge clk);
    req_pulse = '0;
    wait_sync("drop_seen0", s);
    check("drop_id0", 32'(sync_id), 32'd0);
    @(negedge clk);
    req_pulse = 4'b0010;
    @(negedge clk);
    req_pulse = '0;
    check("drop_first_pend", 32'(pending), 32'h2);
    check("drop_first_none", 32'(drop), 32'd0);
    @(negedge clk);
    req_pulse = 4'b0010;
    @(negedge clk);
    req_pulse = '0;
    check("drop_second", 32'(drop), 32'h2);
    check("drop_second_pend", 32'(pending), 32'h2);
    @(negedge clk);
    check("drop_one_cycle", 32'(drop), 32'd0);
    ack_now();
    wait_sync("drop_seen1", s);
    check("drop_id1", 32'(sync_id), 32'd1);
    ack_now();
    wait_idle("drop_idle");
    check("drop_pend_final", 32'(pending), 32'd0);
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (sync_pulse === 1'b1) cnt++;
    end
    check("drop_served_once", 32'(cnt), 32'd0);

    // Same-edge set/clear on requester 3.
    req_pulse = 4'b1000;
    @(negedge clk);
    check("same_pend", 32'(pending), 32'h8);
    check("same_no_drop0", 32'(drop), 32'd0);
    @(negedge clk);
    req_pulse = '0;
    check("same_pulse", 32'(sync_pulse), 32'd1);
    check("same_id", 32'(sync_id), 32'd3);
    check("same_pend_kept", 32'(pending), 32'h8);
    check("same_no_drop", 32'(drop), 32'd0);
    @(negedge clk);
    ack_now();
    wait_sync("same_seen2", s);
    check("same_id2", 32'(sync_id), 32'd3);
    ack_now();
    wait_idle("same_idle");
    check("same_pend_final", 32'(pending), 32'd0);

    // Timeout: decided in the 64th WAIT_ACK cycle, registered out the next cycle.
    req_pulse = 4'b0001;
    @(negedge clk);
    req_pulse = '0;
    wait_sync("to_seen", s);
    check("to_id", 32'(sync_id), 32'd0);
    cnt = 0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (i == 1) req_pulse = 4'b0100;
      if (i == 2) req_pulse = '0;
      if (timeout_err === 1'b1) cnt++;
    end
    check("to_early", 32'(cnt), 32'd0);
    check("to_still_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("to_err", 32'(timeout_err), 32'd1);
    check("to_gap_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("to_err_one_cycle", 32'(timeout_err), 32'd0);
    wait_sync("to_next_seen", s2);
    check("to_next_delay", 32'(s2 - s), 32'd69);
    check("to_next_id", 32'(sync_id), 32'd2);
    cnt = 0;
    repeat (64) begin
      @(negedge clk);
      if (timeout_err === 1'b1) cnt++;
    end
    ack_now();
    check("ack64_no_err_early", 32'(cnt), 32'd0);
    check("ack64_no_err", 32'(timeout_err), 32'd0);
    check("ack64_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("ack64_no_err2", 32'(timeout_err), 32'd0);
    wait_idle("ack64_idle");

    // Asynchronous reset in WAIT_ACK with pending=1010.
    req_pulse = 4'b0001;
    @(negedge clk);
    req_pulse = '0;
    wait_sync("rst_mid_seen", s);
    @(negedge clk);
    req_pulse = 4'b1010;
    @(negedge clk);
    req_pulse = '0;
    check("rst_mid_pend", 32'(pending), 32'hA);
    check("rst_mid_busy", 32'(busy), 32'd1);
    #2 n_rst = 1'b0;
    #1;
    check("rst_mid_busy0", 32'(busy), 32'd0);
    check("rst_mid_pend0", 32'(pending), 32'd0);
    check("rst_mid_pulse0", 32'(sync_pulse), 32'd0);
    check("rst_mid_err0", 32'(timeout_err), 32'd0);
    check("rst_mid_id0", 32'(sync_id), 32'd0);
    check("rst_mid_drop0", 32'(drop), 32'd0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (sync_pulse === 1'b1 || busy === 1'b1) cnt++;
    end
    check("rst_mid_quiet", 32'(cnt), 32'd0);
    req_pulse = 4'b0100;
    @(negedge clk);
    req_pulse = '0;
    wait_sync("rst_mid_new_seen", s);
    check("rst_mid_new_id", 32'(sync_id), 32'd2);
    ack_now();
    wait_idle("rst_mid_idle");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
